// File: rtl/poly1305_bus_driver.sv
// Bus initiator that runs a complete Poly1305 MAC through the poly1305 register wrapper.
// All outputs are registered; bus fields are loaded on the edge that enters their state.
module poly1305_bus_driver #(
    parameter int unsigned POLL_DELAY = 3,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_start,
    input  logic [255:0] i_key,
    output logic         o_busy,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [127:0] i_blk_data,
    input  logic [4:0]   i_blk_len,
    input  logic         i_blk_last,
    output logic         o_mac_valid,
    output logic [127:0] o_mac,
    output logic         o_error,
    output logic         o_cs,
    output logic         o_we,
    output logic [7:0]   o_address,
    output logic [31:0]  o_write_data,
    input  logic [31:0]  i_read_data
);

    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h09;
    localparam logic [7:0] ADDR_BLOCKLEN = 8'h0a;
    localparam logic [7:0] ADDR_KEY      = 8'h10;
    localparam logic [7:0] ADDR_KEY_LAST = 8'h17;
    localparam logic [7:0] ADDR_BLOCK    = 8'h20;
    localparam logic [7:0] ADDR_BLK_LAST = 8'h23;
    localparam logic [7:0] ADDR_MAC      = 8'h30;
    localparam logic [7:0] ADDR_MAC_LAST = 8'h33;

    localparam int unsigned DW = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;
    localparam int unsigned PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        StIdle, StWrKey, StWrInit, StDelay, StPoll, StWaitBlk,
        StWrBlk, StWrLen, StWrNext, StWrFinish, StRdMac, StDone
    } state_t;

    typedef enum logic [1:0] {PtInit, PtNext, PtFinish} poll_tgt_t;

    state_t        r_state;
    poll_tgt_t     r_poll_tgt;
    logic [41:0]   r_bus;        // {cs, we, address, write_data}
    logic          r_busy;
    logic          r_blk_ready;
    logic          r_mac_valid;
    logic          r_error;
    logic [127:0]  r_mac;
    logic [95:0]   r_mac_buf;
    logic [223:0]  r_key;        // key words still to be written, next word in the top bits
    logic [95:0]   r_blk;        // block words still to be written, next word in the top bits
    logic [4:0]    r_len;
    logic          r_last;
    logic [DW-1:0] r_dly_cnt;
    logic [PW-1:0] r_poll_cnt;

    logic [4:0]    w_blk_len_sat;

    assign w_blk_len_sat = (i_blk_len > 5'd16) ? 5'd16 : i_blk_len;

    function automatic logic [41:0] f_wr(input logic [7:0] addr, input logic [31:0] data);
        return {1'b1, 1'b1, addr, data};
    endfunction

    function automatic logic [41:0] f_rd(input logic [7:0] addr);
        return {1'b1, 1'b0, addr, 32'h0};
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_poll_tgt  <= PtInit;
            r_bus       <= '0;
            r_busy      <= 1'b0;
            r_blk_ready <= 1'b0;
            r_mac_valid <= 1'b0;
            r_error     <= 1'b0;
            r_mac       <= '0;
            r_mac_buf   <= '0;
            r_key       <= '0;
            r_blk       <= '0;
            r_len       <= '0;
            r_last      <= 1'b0;
            r_dly_cnt   <= '0;
            r_poll_cnt  <= '0;
        end else begin
            r_bus       <= '0;
            r_blk_ready <= 1'b0;
            r_mac_valid <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_busy  <= 1'b1;
                        r_key   <= i_key[223:0];
                        r_bus   <= f_wr(ADDR_KEY, i_key[255:224]);
                        r_state <= StWrKey;
                    end
                end
                StWrKey: begin
                    if (r_bus[39:32] == ADDR_KEY_LAST) begin
                        r_bus      <= f_wr(ADDR_CTRL, 32'h1);
                        r_poll_tgt <= PtInit;
                        r_state    <= StWrInit;
                    end else begin
                        r_bus <= f_wr(r_bus[39:32] + 8'd1, r_key[223:192]);
                        r_key <= {r_key[191:0], 32'h0};
                    end
                end
                StWrInit, StWrNext, StWrFinish: begin
                    // The core needs POLL_DELAY quiet cycles after any CTRL write
                    if (POLL_DELAY == 0) begin
                        r_bus      <= f_rd(ADDR_STATUS);
                        r_poll_cnt <= '0;
                        r_state    <= StPoll;
                    end else begin
                        r_dly_cnt <= '0;
                        r_state   <= StDelay;
                    end
                end
                StDelay: begin
                    if (r_dly_cnt == DW'(POLL_DELAY - 1)) begin
                        r_bus      <= f_rd(ADDR_STATUS);
                        r_poll_cnt <= '0;
                        r_state    <= StPoll;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + DW'(1);
                    end
                end
                StPoll: begin
                    if (i_read_data[0]) begin
                        case (r_poll_tgt)
                            PtInit: begin
                                r_blk_ready <= 1'b1;
                                r_state     <= StWaitBlk;
                            end
                            PtNext: begin
                                if (r_last) begin
                                    r_bus      <= f_wr(ADDR_CTRL, 32'h4);
                                    r_poll_tgt <= PtFinish;
                                    r_state    <= StWrFinish;
                                end else begin
                                    r_blk_ready <= 1'b1;
                                    r_state     <= StWaitBlk;
                                end
                            end
                            default: begin
                                r_bus   <= f_rd(ADDR_MAC);
                                r_state <= StRdMac;
                            end
                        endcase
                    end else if (r_poll_cnt == PW'(TIMEOUT - 1)) begin
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + PW'(1);
                        r_bus      <= f_rd(ADDR_STATUS);
                    end
                end
                StWaitBlk: begin
                    if (i_blk_valid) begin
                        r_last <= i_blk_last;
                        r_len  <= w_blk_len_sat;
                        r_blk  <= i_blk_data[95:0];
                        if (i_blk_len != 5'd0) begin
                            r_bus   <= f_wr(ADDR_BLOCK, i_blk_data[127:96]);
                            r_state <= StWrBlk;
                        end else if (i_blk_last) begin
                            r_bus      <= f_wr(ADDR_CTRL, 32'h4);
                            r_poll_tgt <= PtFinish;
                            r_state    <= StWrFinish;
                        end else begin
                            // Empty non-final block: drop it and keep accepting
                            r_blk_ready <= 1'b1;
                        end
                    end else begin
                        r_blk_ready <= 1'b1;
                    end
                end
                StWrBlk: begin
                    if (r_bus[39:32] == ADDR_BLK_LAST) begin
                        r_bus   <= f_wr(ADDR_BLOCKLEN, {27'h0, r_len});
                        r_state <= StWrLen;
                    end else begin
                        r_bus <= f_wr(r_bus[39:32] + 8'd1, r_blk[95:64]);
                        r_blk <= {r_blk[63:0], 32'h0};
                    end
                end
                StWrLen: begin
                    r_bus      <= f_wr(ADDR_CTRL, 32'h2);
                    r_poll_tgt <= PtNext;
                    r_state    <= StWrNext;
                end
                StRdMac: begin
                    if (r_bus[39:32] == ADDR_MAC_LAST) begin
                        r_mac       <= {r_mac_buf, i_read_data};
                        r_mac_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StDone;
                    end else begin
                        r_mac_buf <= {r_mac_buf[63:0], i_read_data};
                        r_bus     <= f_rd(r_bus[39:32] + 8'd1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cs         = r_bus[41];
    assign o_we         = r_bus[40];
    assign o_address    = r_bus[39:32];
    assign o_write_data = r_bus[31:0];
    assign o_busy       = r_busy;
    assign o_blk_ready  = r_blk_ready;
    assign o_mac_valid  = r_mac_valid;
    assign o_mac        = r_mac;
    assign o_error      = r_error;

endmodule
